// File: rtl/csr_machine_file_pkg.sv
`default_nettype none
// ============================================================================
// Module : csr_machine_file_pkg
// Brief  : CSR addresses, operation encoding, request structs, interrupt
//          causes and bit indices shared by the M-mode CSR file.
// Rev    : 1.0  initial release
// ============================================================================
package csr_machine_file_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Zicsr operation; 2'b00 never issued by the requester
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef struct packed {
    logic        valid;
    csr_op_e     op;
    logic [11:0] addr;
    logic        wen;
  } csr_pkt_t;

  typedef struct packed {
    logic        valid;
    logic        mret;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] tval;
  } trap_req_t;

  // Interrupt causes (interrupt bit set)
  localparam logic [31:0] IRQ_CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] IRQ_CAUSE_MTI = 32'h8000_0007;

  // mstatus / mie / mip bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MSIE     = 3;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;
  localparam logic [31:0] MIE_MASK = (32'd1 << MIE_MSIE) | (32'd1 << MIE_MTIE) | (32'd1 << MIE_MEIE);

  // New CSR value for a read-modify-write operation
  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val, logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_val | wdata;
      CSR_OP_RC: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_interface.sv
`default_nettype none
// ============================================================================
// Module : csr_interface
// Brief  : CSR access channel between EX (requester) and the CSR file
//          (completer): access packet, write data, trap request, read data.
// Rev    : 1.0  initial release
// ============================================================================
interface csr_interface;
  import csr_machine_file_pkg::*;

  csr_pkt_t    pkt;
  logic [31:0] wdata;
  trap_req_t   trap;
  logic [31:0] rdata;

  modport completer (input pkt, input wdata, input trap, output rdata);
  modport requester (output pkt, output wdata, output trap, input rdata);
endinterface
`default_nettype wire

// File: rtl/csr_machine_file_counter64.sv
`default_nettype none
// ============================================================================
// Module : csr_counter64
// Brief  : 64-bit free-running counter with independently writable halves.
//          A write to either half replaces that half, holds the other and
//          suppresses the increment for that cycle.
// Rev    : 1.0  initial release
// ============================================================================
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] count;

  // Count, or load one half; a load takes precedence over the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata;
      if (wr_hi) count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

  assign value = count;

endmodule
`default_nettype wire

// File: rtl/csr_machine_file.sv
`default_nettype none
// ============================================================================
// Module : csr_machine_file
// Brief  : RV32 machine-mode CSR file: storage, zero-latency read mux,
//          trap/mret state update, interrupt pending logic and the 64-bit
//          cycle/instret counters.
// Rev    : 1.0  initial release
// ============================================================================
module csr_machine_file
  import csr_machine_file_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  csr_interface.completer        csr_if,
  input  logic                   instret_inc,
  input  logic                   irq_ext,
  input  logic                   irq_timer,
  output logic [31:0]            mtvec_o,
  output logic [31:0]            mepc_o,
  output logic                   irq_take,
  output logic [31:0]            irq_cause,
  output logic                   csr_illegal
);

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic        ext_sync1;
  logic        ext_sync2;
  logic        mtip_q;

  logic [31:0] mstatus_val;
  logic [31:0] mip_val;
  logic [31:0] irq_pend;
  logic [63:0] mcycle_val;
  logic [63:0] minstret_val;
  logic [31:0] rdata;
  logic        implemented;
  logic        read_only;
  logic        wr_en;
  logic [31:0] wr_val;
  logic [11:0] addr;

  assign addr        = csr_if.pkt.addr;
  // MPP is hardwired to machine mode
  assign mstatus_val = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
  assign mip_val     = {20'd0, ext_sync2, 3'd0, mtip_q, 7'd0};

  // Address decode and pre-write read mux
  always_comb begin
    rdata       = 32'd0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (addr)
      CSR_MSTATUS:   rdata = mstatus_val;
      CSR_MISA:      rdata = MISA_VAL;
      CSR_MIE:       rdata = mie_q;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MTVAL:     rdata = mtval_q;
      CSR_MIP:       rdata = mip_val;
      CSR_MCYCLE:    rdata = mcycle_val[31:0];
      CSR_MCYCLEH:   rdata = mcycle_val[63:32];
      CSR_MINSTRET:  rdata = minstret_val[31:0];
      CSR_MINSTRETH: rdata = minstret_val[63:32];
      CSR_CYCLE:     begin rdata = mcycle_val[31:0];    read_only = 1'b1; end
      CSR_CYCLEH:    begin rdata = mcycle_val[63:32];   read_only = 1'b1; end
      CSR_INSTRET:   begin rdata = minstret_val[31:0];  read_only = 1'b1; end
      CSR_INSTRETH:  begin rdata = minstret_val[63:32]; read_only = 1'b1; end
      CSR_MHARTID:   begin rdata = HART_ID;             read_only = 1'b1; end
      default:       implemented = 1'b0;
    endcase
  end

  assign csr_if.rdata = rdata;
  assign csr_illegal  = csr_if.pkt.valid & (~implemented | (csr_if.pkt.wen & read_only));
  assign wr_en        = csr_if.pkt.valid & csr_if.pkt.wen & ~csr_illegal;
  assign wr_val       = csr_apply(csr_if.pkt.op, rdata, csr_if.wdata);

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (wr_en && addr == CSR_MCYCLE),
    .wr_hi (wr_en && addr == CSR_MCYCLEH),
    .wdata (wr_val),
    .value (mcycle_val)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instret_inc),
    .wr_lo (wr_en && addr == CSR_MINSTRET),
    .wr_hi (wr_en && addr == CSR_MINSTRETH),
    .wdata (wr_val),
    .value (minstret_val)
  );

  // Trap-related state: trap beats mret beats a CSR write to the same registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mepc_q       <= 32'd0;
      mcause_q     <= 32'd0;
      mtval_q      <= 32'd0;
    end else if (csr_if.trap.valid) begin
      mepc_q       <= csr_if.trap.pc & ~32'd3;
      mcause_q     <= csr_if.trap.cause;
      mtval_q      <= csr_if.trap.tval;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else begin
      if (csr_if.trap.mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_en && addr == CSR_MSTATUS) begin
        mstatus_mie  <= wr_val[MSTATUS_MIE];
        mstatus_mpie <= wr_val[MSTATUS_MPIE];
      end
      if (wr_en && addr == CSR_MEPC)   mepc_q   <= wr_val & ~32'd3;
      if (wr_en && addr == CSR_MCAUSE) mcause_q <= wr_val;
      if (wr_en && addr == CSR_MTVAL)  mtval_q  <= wr_val;
    end
  end

  // CSRs untouched by trap/mret commit on any legal write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 32'd0;
      mtvec_q    <= MTVEC_RESET & ~32'd3;
      mscratch_q <= 32'd0;
    end else if (wr_en) begin
      if (addr == CSR_MIE)      mie_q      <= wr_val & MIE_MASK;
      if (addr == CSR_MTVEC)    mtvec_q    <= wr_val & ~32'd3;
      if (addr == CSR_MSCRATCH) mscratch_q <= wr_val;
    end
  end

  // External irq through two synchronizer flops; timer irq registered once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_sync1 <= 1'b0;
      ext_sync2 <= 1'b0;
      mtip_q    <= 1'b0;
    end else begin
      ext_sync1 <= irq_ext;
      ext_sync2 <= ext_sync1;
      mtip_q    <= irq_timer;
    end
  end

  assign irq_pend  = mip_val & mie_q;
  assign irq_take  = mstatus_mie & (|irq_pend);
  assign irq_cause = irq_pend[MIE_MEIE] ? IRQ_CAUSE_MEI :
                     irq_pend[MIE_MTIE] ? IRQ_CAUSE_MTI : 32'd0;
  assign mtvec_o   = mtvec_q;
  assign mepc_o    = mepc_q;

endmodule
`default_nettype wire
